// File: rtl/riscuinho_core_defs.sv
// Shared definitions for the riscuinho core front end: machine word width,
// the canonical NOP, the fetch FSM encoding and a word-alignment helper.
package riscuinho_core_defs;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

    // Instruction fetches are word-sized; the two low address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the fetch FSM and the decoder.
// Supports simultaneous push/pop when full, and a flush that wins over both.
// Underflow pops are ignored; pushes into a full buffer without a pop are ignored.
module fetch_fifo
    import riscuinho_core_defs::*;
#(
    parameter int               DEPTH      = 2,
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_HEAD = '0,
    localparam int              PW         = $clog2(DEPTH),
    localparam int              CW         = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_eff_s;
    logic             push_eff_s;

    // Qualify requests: no pop from empty, no push into full unless a pop frees a slot.
    always_comb begin
        pop_eff_s  = pop && (count_r != {CW{1'b0}});
        push_eff_s = push && ((count_r < CW'(DEPTH)) || pop_eff_s);
    end

    // Storage, pointers and occupancy; flush empties the buffer in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_HEAD;
            end
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_eff_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != {CW{1'b0}});
    assign head_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads over a req/ack
// handshake and buffers {pc, instr} pairs for the decoder. A redirect flushes
// the buffer and restarts fetch; a response already in flight is discarded via
// the KILL state, which keeps the old request on the bus until it is acked.
module instr_fetch_unit
    import riscuinho_core_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic [XLEN-1:0]   fetch_pc_r;
    logic [XLEN-1:0]   fetch_pc_nxt_s;
    logic              imem_req_r;
    logic [XLEN-1:0]   imem_addr_r;
    logic              req_nxt_s;
    logic [XLEN-1:0]   addr_nxt_s;
    logic              misaligned_r;
    logic              xfer_s;
    logic              push_s;
    logic              pop_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     count_after_s;
    logic              room_s;
    logic [2*XLEN-1:0] head_data_s;
    logic              head_valid_s;

    // Handshake decode and the buffer-room check used to (re)enter FETCH.
    always_comb begin
        xfer_s        = imem_req_r && imem_ack;
        push_s        = (state_r == ST_FETCH) && xfer_s && !redirect;
        pop_s         = head_valid_s && out_ready && !redirect;
        count_after_s = count_s + CW'(push_s) - CW'(pop_s);
        room_s        = (count_after_s < CW'(FIFO_DEPTH));
    end

    // Next state and next fetch PC; redirect takes priority over everything.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt_s = word_align(redirect_pc);
                    state_nxt_s    = ST_FETCH;
                end else if (room_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    fetch_pc_nxt_s = word_align(redirect_pc);
                    state_nxt_s    = xfer_s ? ST_FETCH : ST_KILL;
                end else if (xfer_s) begin
                    fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                    state_nxt_s    = room_s ? ST_FETCH : ST_IDLE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (redirect) begin
                    fetch_pc_nxt_s = word_align(redirect_pc);
                    state_nxt_s    = xfer_s ? ST_FETCH : ST_KILL;
                end else if (xfer_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_KILL;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                fetch_pc_nxt_s = fetch_pc_r;
            end
        endcase
    end

    // Bus outputs for the next cycle; KILL keeps the abandoned address on the bus.
    always_comb begin
        req_nxt_s  = (state_nxt_s != ST_IDLE);
        addr_nxt_s = (state_nxt_s == ST_KILL) ? imem_addr_r : fetch_pc_nxt_s;
    end

    // FSM state and program counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
        end
    end

    // Registered memory request and address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
        end else begin
            imem_req_r  <= req_nxt_s;
            imem_addr_r <= addr_nxt_s;
        end
    end

    // Sticky misalignment flag, refreshed by every redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_r <= 1'b0;
        end else if (redirect) begin
            misaligned_r <= |redirect_pc[1:0];
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .WIDTH      (2 * XLEN),
        .RESET_HEAD ({32'h0000_0000, INSTR_NOP})
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .push       (push_s),
        .push_data  ({imem_addr_r, imem_rdata}),
        .pop        (pop_s),
        .flush      (redirect),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s)
    );

    assign imem_req         = imem_req_r;
    assign imem_addr        = imem_addr_r;
    assign fetch_misaligned = misaligned_r;
    assign out_valid        = head_valid_s;
    assign out_pc           = head_data_s[2*XLEN-1:XLEN];
    assign out_instr        = head_data_s[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. The memory model returns
// addr + 32'h1000_0000 as the instruction word, so every output word is
// traceable to the address it was fetched from.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    int total;
    int bad;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 32'h1000_0000;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, check reset values, release away from the edge.
    task automatic test_reset();
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        total++; if (out_instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", out_instr); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
        total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis got=%0b exp=0", fetch_misaligned); end
        reset_n = 1'b1;
    endtask

    // Zero-wait memory and an always-ready decoder give one instruction per cycle.
    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        test_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_addr = 32'(4 * (k - 1));
            total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                bad++; $display("FAIL stream_addr k=%0d got=%0b/%h exp=1/%h", k, imem_req, imem_addr, exp_addr);
            end
            if (k >= 2) begin
                exp_pc = 32'(4 * (k - 2));
                total++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== exp_pc + 32'h1000_0000) begin
                    bad++; $display("FAIL stream_out k=%0d got=%0b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_instr, exp_pc, exp_pc + 32'h1000_0000);
                end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%0b exp=0", out_valid); end
            end
        end
    endtask

    // Stalled decoder: two entries fill the buffer, fetch stops, then resumes at 8.
    task automatic test_backpressure();
        test_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        step(); // req at 0
        step(); // push 0, req at 4
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL bp_req4 got=%0b/%h exp=1/4", imem_req, imem_addr); end
        step(); // push 4, buffer full
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_drop got=%0b exp=0", imem_req); end
        step();
        total++; if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++; $display("FAIL bp_hold got=%0b/%0b/%h exp=0/1/0", imem_req, out_valid, out_pc);
        end
        out_ready = 1'b1;
        step(); // pop 0, restart at 8
        total++; if (out_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            bad++; $display("FAIL bp_resume got=%h/%0b/%h exp=4/1/8", out_pc, imem_req, imem_addr);
        end
        step(); // pop 4, push 8
        total++; if (out_pc !== 32'h8 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_pc8 got=%0b/%h exp=1/8", out_valid, out_pc); end
    endtask

    // Redirect during a waited request: old request held, response dropped.
    task automatic test_wait_redirect();
        test_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        step(); // req 0
        step(); // req 4
        step(); // req 8
        imem_ack = 1'b0;
        step(); // waiting at 8, buffer drains
        total++; if (imem_addr !== 32'h8 || out_valid !== 1'b0) begin bad++; $display("FAIL wr_wait got=%h/%0b exp=8/0", imem_addr, out_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step(); // enters kill, address held
        redirect = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL wr_kill_hold got=%0b/%h exp=1/8", imem_req, imem_addr); end
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_valid !== 1'b0) begin
            bad++; $display("FAIL wr_kill_hold2 got=%0b/%h/%0b exp=1/8/0", imem_req, imem_addr, out_valid);
        end
        imem_ack = 1'b1;
        step(); // killed response discarded, request at 0x100
        total++; if (imem_addr !== 32'h100 || out_valid !== 1'b0) begin bad++; $display("FAIL wr_new_req got=%h/%0b exp=100/0", imem_addr, out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h1000_0100) begin
            bad++; $display("FAIL wr_first_out got=%0b/%h/%h exp=1/100/10000100", out_valid, out_pc, out_instr);
        end
    endtask

    // Redirect coinciding with an ack: buffer flushed, acked word never delivered.
    task automatic test_redirect_on_ack();
        test_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        step(); // req 0
        step(); // push 0, req 4
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL roa_flush got=%0b/%0b/%h exp=0/1/200", out_valid, imem_req, imem_addr);
        end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin bad++; $display("FAIL roa_next got=%0b/%h exp=1/200", out_valid, out_pc); end
    endtask

    // Misaligned redirect target is aligned and flagged; an aligned one clears the flag.
    task automatic test_misaligned();
        test_reset();
        imem_ack    = 1'b0;
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h302;
        step();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'h300 || fetch_misaligned !== 1'b1) begin
            bad++; $display("FAIL mis_set got=%h/%0b exp=300/1", imem_addr, fetch_misaligned);
        end
        step();
        total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%0b exp=1", fetch_misaligned); end
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        total++; if (fetch_misaligned !== 1'b0 || imem_addr !== 32'h300) begin
            bad++; $display("FAIL mis_clear got=%0b/%h exp=0/300", fetch_misaligned, imem_addr);
        end
        imem_ack = 1'b1;
        step();
        total++; if (imem_addr !== 32'h400) begin bad++; $display("FAIL mis_newaddr got=%h exp=400", imem_addr); end
    endtask

    // Asynchronous reset mid-wait clears request and buffer; fetch restarts at RESET_PC.
    task automatic test_async_reset();
        test_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        step(); // req 0
        step(); // push 0, req 4
        imem_ack = 1'b0;
        step(); // waiting on 4
        total++; if (imem_req !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%0b/%0b exp=1/1", imem_req, out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL ar_async got=%0b/%0b/%h exp=0/0/0", imem_req, out_valid, imem_addr);
        end
        step();
        reset_n   = 1'b1;
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL ar_restart got=%0b/%h exp=1/0", imem_req, imem_addr); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL ar_first_out got=%0b/%h exp=1/0", out_valid, out_pc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_wait_redirect();
        test_redirect_on_ack();
        test_misaligned();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
